// File: rtl/data_unpacker_pkg.sv
// Shared types and helpers for the data_unpacker word-to-chunk emitter.
// DATA_UNPACKER_SPARSE_EN adds per-byte enables to each FIFO entry.
package data_unpacker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  // endian: 1 = little-endian word, byte-reversed before chunking
  typedef struct packed {
`ifdef DATA_UNPACKER_SPARSE_EN
    logic [3:0]  byte_en;
`endif
    logic        endian;
    logic [31:0] addr;
    logic [31:0] data;
  } fifo_entry_t;

  localparam int unsigned DEFAULT_OUTPUT_WORD_SIZE = 1;
  localparam int unsigned CHUNKS_PER_WORD          = 4 / DEFAULT_OUTPUT_WORD_SIZE;

  function automatic int unsigned chunks_per_word(input int unsigned output_word_size);
    return 4 / output_word_size;
  endfunction

  function automatic logic [31:0] byte_reverse(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/data_unpacker_fifo.sv
// Synchronous FIFO whose registered read data always shows the current head entry.
module data_unpacker_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_d;
  logic [CW-1:0]    count_d;

  assign rd_ptr_d = pop ? rd_ptr + AW'(1) : rd_ptr;
  assign count_d  = count + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Head is forwarded from the write port when the new head is the slot being written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      rd_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr  <= rd_ptr_d;
      count   <= count_d;
      full    <= (count_d == CW'(DEPTH));
      empty   <= (count_d == '0);
      rd_data <= (push && (wr_ptr == rd_ptr_d)) ? wr_data : mem[rd_ptr_d];
    end
  end

endmodule

// File: rtl/data_unpacker.sv
// Buffers 32-bit addressed words and emits them as paced 8/16/32-bit chunk writes.
// Optional DATA_UNPACKER_SPARSE_EN: per-byte enables skip empty chunks.
module data_unpacker
  import data_unpacker_pkg::*;
#(
  parameter int unsigned OUTPUT_WORD_SIZE          = 1,
  parameter int unsigned ADDRESS_SIZE              = 15,
  parameter int unsigned WRITE_MEM_CLOCK_DELAY     = 4,
  parameter int unsigned WRITE_MEM_EN_CYCLE_LENGTH = 1,
  parameter int unsigned FIFO_DEPTH                = 4
) (
  input  logic                          clk_memory,
  input  logic                          reset_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [31:0]                   in_addr,
  input  logic [31:0]                   in_data,
  input  logic                          in_endian_little,
`ifdef DATA_UNPACKER_SPARSE_EN
  input  logic [3:0]                    in_byte_en,
`endif
  output logic                          write_en,
  output logic [ADDRESS_SIZE-1:0]       write_addr,
  output logic [8*OUTPUT_WORD_SIZE-1:0] write_data,
  output logic                          busy
);

  localparam int unsigned CHUNKS    = chunks_per_word(OUTPUT_WORD_SIZE);
  localparam int unsigned DW        = 8 * OUTPUT_WORD_SIZE;
  localparam int unsigned CW        = $clog2(WRITE_MEM_CLOCK_DELAY);
  localparam int unsigned FCW       = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned EW        = $bits(fifo_entry_t);
  localparam logic [3:0]  FULL_MASK = 4'((1 << CHUNKS) - 1);

  state_t         state_q, state_d;
  fifo_entry_t    in_entry, head, word_q, word_d, emit_src;
  logic [EW-1:0]  in_bits, head_bits;
  logic           push, pop, emit;
  logic           fifo_full, fifo_empty;
  logic [FCW-1:0] fifo_count, fifo_count_d;
  logic [1:0]     k_q, k_d, emit_k;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [3:0]     word_mask, head_mask;
  logic [2:0]     word_first, word_next, head_first;
  logic           we_d;
  logic [ADDRESS_SIZE-1:0] wa_d;
  logic [DW-1:0]  wd_d;

  function automatic logic [31:0] ordered_data(input fifo_entry_t e);
    return e.endian ? byte_reverse(e.data) : e.data;
  endfunction

  function automatic logic [ADDRESS_SIZE-1:0] chunk_addr(input logic [31:0] a, input logic [1:0] idx);
    return ADDRESS_SIZE'((a & ~32'(OUTPUT_WORD_SIZE - 1)) + 32'(idx) * 32'(OUTPUT_WORD_SIZE));
  endfunction

  function automatic logic [DW-1:0] chunk_data(input logic [31:0] ord, input logic [1:0] idx);
    return DW'(ord >> (32'd32 - 32'(DW) * (32'(idx) + 32'd1)));
  endfunction

  // {found, index} of the lowest enabled chunk at or above start
  function automatic logic [2:0] find_chunk(input logic [3:0] m, input int start);
    logic [2:0] r;
    r = '0;
    for (int j = 3; j >= 0; j--) begin
      if (j >= start && j < int'(CHUNKS) && m[2'(j)]) r = {1'b1, 2'(j)};
    end
    return r;
  endfunction

`ifdef DATA_UNPACKER_SPARSE_EN
  function automatic logic [3:0] chunk_mask(input fifo_entry_t e);
    logic [3:0] be, m;
    be = e.endian ? {e.byte_en[0], e.byte_en[1], e.byte_en[2], e.byte_en[3]} : e.byte_en;
    m  = '0;
    for (int i = 0; i < 4; i++) begin
      if (be[2'(3 - i)]) m[2'(i / OUTPUT_WORD_SIZE)] = 1'b1;
    end
    return m;
  endfunction

  assign word_mask = chunk_mask(word_q);
  assign head_mask = chunk_mask(head);
`else
  assign word_mask = FULL_MASK;
  assign head_mask = FULL_MASK;
`endif

  assign word_first = find_chunk(word_mask, 0);
  assign word_next  = find_chunk(word_mask, int'(k_q) + 1);
  assign head_first = find_chunk(head_mask, 0);

  always_comb begin
    in_entry        = '0;
    in_entry.addr   = in_addr;
    in_entry.data   = in_data;
    in_entry.endian = in_endian_little;
`ifdef DATA_UNPACKER_SPARSE_EN
    in_entry.byte_en = in_byte_en;
`endif
  end

  assign in_bits      = in_entry;
  assign head         = head_bits;
  assign push         = in_valid && in_ready && !fifo_full;
  assign fifo_count_d = fifo_count + FCW'(push) - FCW'(pop);

  data_unpacker_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk     (clk_memory),
    .rst_n   (reset_n),
    .push    (push),
    .pop     (pop),
    .wr_data (in_bits),
    .rd_data (head_bits),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Next chunk is chosen at the last slot cycle so the following strobe lands with no gap.
  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    we_d     = write_en;
    wa_d     = write_addr;
    wd_d     = write_data;
    pop      = 1'b0;
    emit     = 1'b0;
    emit_src = word_q;
    emit_k   = '0;

    if (state_q == EMIT || state_q == HOLD) begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(WRITE_MEM_EN_CYCLE_LENGTH - 1)) we_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          word_d  = head;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (word_first[2]) begin
          emit   = 1'b1;
          emit_k = word_first[1:0];
        end else begin
          state_d = IDLE;
        end
      end
      EMIT: state_d = HOLD;
      HOLD: begin
        if (cnt_q == CW'(WRITE_MEM_CLOCK_DELAY - 1)) begin
          if (word_next[2]) begin
            emit   = 1'b1;
            emit_k = word_next[1:0];
          end else if (!fifo_empty) begin
            pop    = 1'b1;
            word_d = head;
            if (head_first[2]) begin
              emit     = 1'b1;
              emit_src = head;
              emit_k   = head_first[1:0];
            end else begin
              state_d = IDLE;
            end
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (emit) begin
      state_d = EMIT;
      k_d     = emit_k;
      cnt_d   = '0;
      we_d    = 1'b1;
      wa_d    = chunk_addr(emit_src.addr, emit_k);
      wd_d    = chunk_data(ordered_data(emit_src), emit_k);
    end
  end

  always_ff @(posedge clk_memory or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      word_q     <= '0;
      k_q        <= '0;
      cnt_q      <= '0;
      write_en   <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      busy       <= 1'b0;
      in_ready   <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      k_q        <= k_d;
      cnt_q      <= cnt_d;
      write_en   <= we_d;
      write_addr <= wa_d;
      write_data <= wd_d;
      busy       <= (state_d != IDLE) || (fifo_count_d != '0);
      in_ready   <= (fifo_count_d != FCW'(FIFO_DEPTH));
    end
  end

endmodule

// File: tb/tb_data_unpacker.sv
// Directed bench for data_unpacker: byte-wide default instance plus a 16-bit chunk instance.
module tb_data_unpacker;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid1, in_valid2, in_ready1, in_ready2;
  logic [31:0] in_addr, in_data;
  logic        in_endian_little;
`ifdef DATA_UNPACKER_SPARSE_EN
  logic [3:0]  in_byte_en;
`endif
  logic        we1, we2, busy1, busy2;
  logic [14:0] wa1, wa2;
  logic [7:0]  wd1;
  logic [15:0] wd2;

  always #5 clk = ~clk;

  data_unpacker dut1 (
    .clk_memory(clk), .reset_n(reset_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_addr(in_addr), .in_data(in_data), .in_endian_little(in_endian_little),
`ifdef DATA_UNPACKER_SPARSE_EN
    .in_byte_en(in_byte_en),
`endif
    .write_en(we1), .write_addr(wa1), .write_data(wd1), .busy(busy1)
  );

  data_unpacker #(.OUTPUT_WORD_SIZE(2)) dut2 (
    .clk_memory(clk), .reset_n(reset_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_addr(in_addr), .in_data(in_data), .in_endian_little(in_endian_little),
`ifdef DATA_UNPACKER_SPARSE_EN
    .in_byte_en(in_byte_en),
`endif
    .write_en(we2), .write_addr(wa2), .write_data(wd2), .busy(busy2)
  );

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        le;
    logic [31:0] exp_base;
    logic [31:0] exp_stream;
  } vec_t;

  wr_t  q1[$], q2[$];
  int   cyc = 0;
  int   n_checks = 0, n_fail = 0;
  int   hi1 = 0, busy_last1 = 0;
  logic pwe1 = 1'b0, pwe2 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Records each write_en rising edge with the edge number it followed.
  always @(negedge clk) begin
    if (we1 && !pwe1) q1.push_back('{cyc, 32'(wa1), 32'(wd1)});
    if (we2 && !pwe2) q2.push_back('{cyc, 32'(wa2), 32'(wd2)});
    if (we1) hi1++;
    if (busy1) busy_last1 = cyc;
    pwe1 = we1;
    pwe2 = we2;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves in_valid high; returns the edge number at which the push happened.
  task automatic push(input int which, input logic [31:0] a, input logic [31:0] d,
                      input logic le, output int n);
    int b;
    b = 0;
    in_addr = a; in_data = d; in_endian_little = le;
    if (which == 1) in_valid1 = 1'b1; else in_valid2 = 1'b1;
    while (((which == 1) ? !in_ready1 : !in_ready2) && b < 200) begin
      tick(1);
      b++;
    end
    if (b >= 200) begin
      n_checks++; n_fail++;
      $display("FAIL push_ready_timeout: in_ready stayed low for %0d cycles", b);
    end
    tick(1);
    n = cyc;
  endtask

  task automatic chk_wr(input string name, input wr_t w, input int ecyc,
                        input logic [31:0] ea, input logic [31:0] ed);
    chk({name, "_cyc"}, 64'(w.cyc), 64'(ecyc));
    chk({name, "_addr"}, w.addr, ea);
    chk({name, "_data"}, w.data, ed);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[2];
    int   n, n0;
    tbl[0] = '{32'h0000_000C, 32'hAABBCCDD, 1'b0, 32'h0000_000C, 32'hAABBCCDD};
    tbl[1] = '{32'h0000_0020, 32'hFFEEDDCC, 1'b1, 32'h0000_0020, 32'hCCDDEEFF};

    reset_n = 1'b0; in_valid1 = 1'b0; in_valid2 = 1'b0;
    in_addr = '0; in_data = '0; in_endian_little = 1'b0;
`ifdef DATA_UNPACKER_SPARSE_EN
    in_byte_en = 4'hF;
`endif
    tick(3);
    chk("rst_write_en", we1, 0);
    chk("rst_write_addr", wa1, 0);
    chk("rst_write_data", wd1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_in_ready", in_ready1, 0);
    reset_n = 1'b1;
    tick(1);
    chk("in_ready_after_release", in_ready1, 1);

    // Single words, byte chunks, both byte orders
    for (int t = 0; t < 2; t++) begin
      q1.delete(); hi1 = 0;
      push(1, tbl[t].addr, tbl[t].data, tbl[t].le, n);
      in_valid1 = 1'b0;
      tick(24);
      chk($sformatf("t%0d_count", t), 64'(q1.size()), 4);
      for (int i = 0; i < 4 && i < q1.size(); i++)
        chk_wr($sformatf("t%0d_w%0d", t, i), q1[i], n + 2 + 4 * i,
               tbl[t].exp_base + 32'(i), 32'(tbl[t].exp_stream[31 - 8 * i -: 8]));
      chk($sformatf("t%0d_we_high_cycles", t), 64'(hi1), 4);
      chk($sformatf("t%0d_busy_last", t), 64'(busy_last1), 64'(n + 17));
      chk($sformatf("t%0d_busy_idle", t), busy1, 0);
    end

    // 16-bit chunks from an unaligned address
    q2.delete();
    push(2, 32'h0000_0101, 32'h11223344, 1'b0, n);
    in_valid2 = 1'b0;
    tick(16);
    chk("w16_count", 64'(q2.size()), 2);
    if (q2.size() >= 2) begin
      chk_wr("w16_c0", q2[0], n + 2, 32'h100, 32'h1122);
      chk_wr("w16_c1", q2[1], n + 6, 32'h102, 32'h3344);
    end

    // Five back-to-back words into a four-deep FIFO
    q1.delete(); hi1 = 0; n0 = 0;
    for (int w = 0; w < 5; w++) begin
      push(1, 32'h100 + 32'(4 * w), 32'h00010203 + 32'(w) * 32'h04040404, 1'b0, n);
      if (w == 0) n0 = n;
    end
    in_valid1 = 1'b0;
    chk("b2b_full_ready_low", in_ready1, 0);
    tick(100);
    chk("b2b_count", 64'(q1.size()), 20);
    for (int j = 0; j < 20 && j < q1.size(); j++)
      chk_wr($sformatf("b2b_w%0d", j), q1[j], n0 + 2 + 4 * j, 32'h100 + 32'(j), 32'(j));
    chk("b2b_we_high_cycles", 64'(hi1), 20);
    chk("b2b_ready_restored", in_ready1, 1);

`ifdef DATA_UNPACKER_SPARSE_EN
    q1.delete();
    in_byte_en = 4'b1010;
    push(1, 32'h0000_000C, 32'hAABBCCDD, 1'b0, n);
    in_valid1 = 1'b0;
    in_byte_en = 4'hF;
    tick(20);
    chk("sparse_count", 64'(q1.size()), 2);
    if (q1.size() >= 2) begin
      chk_wr("sparse_c0", q1[0], n + 2, 32'hC, 32'hAA);
      chk_wr("sparse_c1", q1[1], n + 6, 32'hE, 32'hCC);
    end
`endif

    // Reset after the second byte of a word with two more queued
    q1.delete();
    push(1, 32'h200, 32'h11223344, 1'b0, n);
    push(1, 32'h204, 32'h55667788, 1'b0, n);
    push(1, 32'h208, 32'h99AABBCC, 1'b0, n);
    in_valid1 = 1'b0;
    for (int b = 0; b < 40 && q1.size() < 2; b++) @(negedge clk);
    chk("rst_mid_setup", 64'(q1.size()), 2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_write_en", we1, 0);
    chk("rst_mid_busy", busy1, 0);
    chk("rst_mid_in_ready", in_ready1, 0);
    tick(2);
    reset_n = 1'b1;
    q1.delete();
    tick(40);
    chk("rst_no_writes", 64'(q1.size()), 0);
    chk("rst_idle_busy", busy1, 0);
    push(1, 32'h300, 32'h55667788, 1'b0, n);
    in_valid1 = 1'b0;
    tick(24);
    chk("rst_fresh_count", 64'(q1.size()), 4);
    if (q1.size() >= 4) begin
      chk_wr("rst_fresh_c0", q1[0], n + 2, 32'h300, 32'h55);
      chk_wr("rst_fresh_c3", q1[3], n + 14, 32'h303, 32'h88);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_unpacker.md
Name: data_unpacker

Overview:
- Single-clock successor to the bridge data loader, in the memory clock domain.
- Accepts 32-bit words with byte addresses through a valid/ready handshake and buffers them in a small FIFO.
- Emits each word as 8/16/32-bit chunks on a paced write strobe (write_en) for BRAM/SDRAM loaders.
- Supports selectable byte order and back-to-back words with no inter-word gap.

Parameters:
- OUTPUT_WORD_SIZE, 1, chunk size in bytes; legal values 1, 2, 4.
- ADDRESS_SIZE, 15, width of write_addr in bits; byte address.
- WRITE_MEM_CLOCK_DELAY, 4, cycles between successive write_en rising edges; must be at least 2.
- WRITE_MEM_EN_CYCLE_LENGTH, 1, cycles write_en is held high; must be less than WRITE_MEM_CLOCK_DELAY.
- FIFO_DEPTH, 4, number of input words buffered; power of two, at least 2.

Ports:
- clk_memory  in  1  sole clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word present.
- in_ready  out  1  FIFO can accept a word.
- in_addr  in  32  byte address of the word's first byte.
- in_data  in  32  word data.
- in_endian_little  in  1  byte order of in_data, sampled with the word.
- write_en  out  1  write strobe.
- write_addr  out  ADDRESS_SIZE  chunk byte address.
- write_data  out  8*OUTPUT_WORD_SIZE  chunk data.
- busy  out  1  FIFO non-empty or emission in progress.

Behaviour:
- Reset (asynchronous, active low): write_en=0, write_addr=0, write_data=0, busy=0, in_ready=0 while asserted, FIFO empty, FSM in IDLE. in_ready rises the first cycle after release.
- Reset mid-emission: the word in flight and all queued words are discarded; no further write_en.
- Handshake:
  - A push occurs on any edge where in_valid and in_ready are both high.
  - in_ready = !full; it may depend only on registered state.
  - A push and a pop in the same cycle are legal at any fill level.
- Byte ordering:
  - Big-endian: byte order is in_data[31:24], [23:16], [15:8], [7:0].
  - Little-endian: the word is byte-reversed first.
  - Chunks are taken from this ordered byte stream, first byte in the MSB of write_data.
- Chunk addressing:
  - Chunk k has address (in_addr with its low log2(OUTPUT_WORD_SIZE) bits cleared) + k*OUTPUT_WORD_SIZE, truncated to ADDRESS_SIZE.
  - The address wraps silently at the truncation boundary.
- FSM:
  - IDLE: when the FIFO is non-empty, pop and go to LOAD.
  - LOAD: latch the word, set k=0, go to EMIT.
  - EMIT: drive write_addr/write_data, assert write_en, go to HOLD.
  - HOLD: count to WRITE_MEM_CLOCK_DELAY.
    - write_en drops after WRITE_MEM_EN_CYCLE_LENGTH cycles.
    - write_addr/write_data stay stable for the full period.
    - At the end of the count: if k < 4/OUTPUT_WORD_SIZE-1, increment k and go to EMIT.
    - Otherwise, if the FIFO is non-empty, pop and re-enter EMIT with the new word at k=0, with no extra cycle; else go to IDLE.
- Latency: a word pushed at edge N produces its first write_en at edge N+2 from IDLE.
- Pacing: write_en rising edges are exactly WRITE_MEM_CLOCK_DELAY cycles apart while busy, including across word boundaries.
- Outputs hold their last value in IDLE; write_en=0.

Optional Feature:
- DATA_UNPACKER_SPARSE_EN defined:
  - Adds input in_byte_en[3:0], in data byte-lane order, bit 3 = in_data[31:24], stored per FIFO entry and reordered with the data.
  - A chunk whose byte enables are all zero is skipped: no write_en, no pacing slot consumed.
  - A word with all enables zero is dropped without emission.
- Undefined: the port is absent and all bytes are written.

Decomposition:
- data_unpacker_pkg:
  - FSM state enum: IDLE, LOAD, EMIT, HOLD.
  - FIFO entry struct: addr, data, endian, optional byte_en.
  - Constant CHUNKS_PER_WORD = 4/OUTPUT_WORD_SIZE.
  - Byte-reverse function.
- Sub-module data_unpacker_fifo:
  - Synchronous FIFO parameterised by depth and entry width.
  - Provides full, empty, push, pop and registered read data.

Test Plan:
- Defaults, push addr 0xC, data 0xAABBCCDD big-endian at edge N -> write_en pulses at N+2/N+6/N+10/N+14 with (0xC,0xAA), (0xD,0xBB), (0xE,0xCC), (0xF,0xDD); write_en low in between; busy drops after N+17.
- Little-endian 0xFFEEDDCC at 0x20 -> (0x20,0xCC), (0x21,0xDD), (0x22,0xEE), (0x23,0xFF).
- OUTPUT_WORD_SIZE=2, push 0x11223344 at addr 0x101 -> (0x100,0x1122), (0x102,0x3344), pulses 4 cycles apart.
- Push 5 words back-to-back with FIFO_DEPTH=4 -> in_ready low while full; all 20 bytes emitted in order with uniform 4-cycle spacing and no gap at word boundaries.
- Assert reset_n after the second byte of a word with two words queued -> write_en=0 immediately, busy=0; no further writes after release; a fresh word emits from its own address.
- With DATA_UNPACKER_SPARSE_EN, push 0xAABBCCDD with in_byte_en=4'b1010 at 0xC -> only (0xC,0xAA) and (0xE,0xCC), 4 cycles apart.
